// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Funnels the cpu's imem/dmem request ports onto one single-port
//               memory. One transaction is in flight at a time. Contended
//               grants alternate between the two sides. A watchdog flags a
//               memory that never responds.
//               Optional perf counters are enabled by MEM_PORT_ARBITER_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH/8-1:0] imem_rmask,
  output logic [DATA_WIDTH-1:0]   imem_rdata,
  output logic                    imem_resp,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr,
  input  logic [DATA_WIDTH/8-1:0] dmem_rmask,
  input  logic [DATA_WIDTH/8-1:0] dmem_wmask,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    dmem_resp,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_rmask,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic                    timeout_err
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]             perf_i_grants,
  output logic [31:0]             perf_d_grants,
  output logic [31:0]             perf_conflict_stalls
`endif
);

  localparam int c_MASK_W = DATA_WIDTH / 8;
  localparam int c_CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_d_q, last_d_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [c_MASK_W-1:0]   mem_rmask_q, mem_rmask_d;
  logic [c_MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [c_CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic                  terr_q, terr_d;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_busy;

  assign w_i_req = |imem_rmask;
  assign w_d_req = (|dmem_rmask) | (|dmem_wmask);
  assign w_busy  = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_addr_d  = mem_addr_q;
    mem_rmask_d = mem_rmask_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Under contention the side that did not win last time goes first.
        if (w_i_req && w_d_req) begin
          w_grant_i = last_d_q;
          w_grant_d = !last_d_q;
        end else begin
          w_grant_i = w_i_req;
          w_grant_d = w_d_req;
        end

        if (w_grant_d) begin
          state_d     = ST_BUSY_D;
          last_d_d    = 1'b1;
          mem_addr_d  = dmem_addr;
          mem_rmask_d = dmem_rmask;
          mem_wmask_d = dmem_wmask;
          mem_wdata_d = dmem_wdata;
        end else if (w_grant_i) begin
          state_d     = ST_BUSY_I;
          last_d_d    = 1'b0;
          mem_addr_d  = imem_addr;
          mem_rmask_d = imem_rmask;
          mem_wmask_d = '0;
          mem_wdata_d = '0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_resp) begin
          state_d     = ST_IDLE;
          mem_rmask_d = '0;
          mem_wmask_d = '0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_rmask_d = '0;
        mem_wmask_d = '0;
      end
    endcase
  end

  // Watchdog counts stalled busy cycles and saturates once it has fired.
  always_comb begin
    wd_cnt_d = '0;
    if (w_busy && !mem_resp) begin
      wd_cnt_d = (wd_cnt_q == c_TIMEOUT) ? wd_cnt_q : wd_cnt_q + c_CNT_W'(1);
    end
    terr_d = terr_q | (w_busy && !mem_resp && (wd_cnt_d == c_TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_d_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      wd_cnt_q    <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_addr_q  <= mem_addr_d;
      mem_rmask_q <= mem_rmask_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      wd_cnt_q    <= wd_cnt_d;
      terr_q      <= terr_d;
    end
`ifndef SYNTHESIS
    if (!rst && (state_q == ST_IDLE) && mem_resp) begin
      $error("mem_port_arbiter: mem_resp received while idle");
    end
`endif
  end

  // Responses are steered combinationally; a reset cycle drops any response.
  assign imem_resp   = !rst && (state_q == ST_BUSY_I) && mem_resp;
  assign dmem_resp   = !rst && (state_q == ST_BUSY_D) && mem_resp;
  assign imem_rdata  = imem_resp ? mem_rdata : '0;
  assign dmem_rdata  = dmem_resp ? mem_rdata : '0;
  assign mem_addr    = mem_addr_q;
  assign mem_rmask   = mem_rmask_q;
  assign mem_wmask   = mem_wmask_q;
  assign mem_wdata   = mem_wdata_q;
  assign timeout_err = terr_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_i_q, perf_d_q, perf_stall_q;
  logic        w_stall;

  // A side stalls when it requests while the other side owns or wins the port.
  assign w_stall = ((state_q == ST_BUSY_I) && w_d_req) ||
                   ((state_q == ST_BUSY_D) && w_i_req) ||
                   ((state_q == ST_IDLE) && w_i_req && w_d_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_i_q     <= '0;
      perf_d_q     <= '0;
      perf_stall_q <= '0;
    end else begin
      if (w_grant_i && !w_grant_d) perf_i_q <= perf_i_q + 32'd1;
      if (w_grant_d) perf_d_q <= perf_d_q + 32'd1;
      if (w_stall) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_i_grants        = perf_i_q;
  assign perf_d_grants        = perf_d_q;
  assign perf_conflict_stalls = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a transaction
//               level reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [3:0]    imem_rmask;
  logic [DW-1:0] imem_rdata;
  logic          imem_resp;
  logic [AW-1:0] dmem_addr;
  logic [3:0]    dmem_rmask;
  logic [3:0]    dmem_wmask;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_resp;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_rmask;
  logic [3:0]    mem_wmask;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_resp;
  logic          timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_rmask  (mem_rmask),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing store seen by the memory responder.
  bit [31:0] shmem [bit [31:0]];

  function automatic logic [31:0] shrd(input logic [31:0] a);
    return shmem.exists(a) ? shmem[a] : 32'h0;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  // Owner: 0 = nobody, 1 = imem, 2 = dmem. Last winner starts as imem.
  bit        m_valid = 1'b0;
  int        m_owner, m_last, m_cnt;
  bit        m_terr;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_rm, m_wm;
  int        i_resp_cnt = 0;
  int        d_resp_cnt = 0;

  always @(negedge clk) begin
    bit e_ir, e_dr, iq, dq;
    int win;
    if (m_valid) begin
      e_ir = (m_owner == 1) && mem_resp && !rst;
      e_dr = (m_owner == 2) && mem_resp && !rst;
      check("mem_addr",    mem_addr,    m_addr);
      check("mem_rmask",   mem_rmask,   m_rm);
      check("mem_wmask",   mem_wmask,   m_wm);
      check("mem_wdata",   mem_wdata,   m_wd);
      check("imem_resp",   imem_resp,   e_ir);
      check("dmem_resp",   dmem_resp,   e_dr);
      check("imem_rdata",  imem_rdata,  e_ir ? mem_rdata : 32'h0);
      check("dmem_rdata",  dmem_rdata,  e_dr ? mem_rdata : 32'h0);
      check("timeout_err", timeout_err, m_terr);
    end
    if (imem_resp) i_resp_cnt++;
    if (dmem_resp) d_resp_cnt++;

    if (rst) begin
      m_owner = 0; m_last = 1; m_cnt = 0; m_terr = 0;
      m_addr = 0; m_rm = 0; m_wm = 0; m_wd = 0;
      m_valid = 1'b1;
    end else if (m_owner == 0) begin
      m_cnt = 0;
      iq = (imem_rmask != 0);
      dq = (dmem_rmask != 0) || (dmem_wmask != 0);
      win = (iq && dq) ? (m_last == 1 ? 2 : 1) : (dq ? 2 : (iq ? 1 : 0));
      if (win == 1) begin
        m_addr = imem_addr; m_rm = imem_rmask; m_wm = 0; m_wd = 0;
      end else if (win == 2) begin
        m_addr = dmem_addr; m_rm = dmem_rmask; m_wm = dmem_wmask; m_wd = dmem_wdata;
      end
      if (win != 0) begin
        m_owner = win;
        m_last  = win;
      end
    end else if (mem_resp) begin
      m_rm = 0; m_wm = 0; m_owner = 0; m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt >= TO) m_terr = 1'b1;
    end
  end

  // ---------------- memory responder + cycle stepping ----------------
  bit auto_mem  = 1'b1;
  bit counting  = 1'b0;
  int left      = 0;
  int min_delay = 1;
  int max_delay = 1;

  task automatic responder();
    logic [31:0] w;
    mem_resp  = 1'b0;
    mem_rdata = $urandom();
    if (!auto_mem) return;
    if ((mem_rmask | mem_wmask) == 4'h0) begin
      counting = 1'b0;
      return;
    end
    if (!counting) begin
      counting = 1'b1;
      left = $urandom_range(min_delay, max_delay);
    end
    if (left == 0) begin
      mem_resp  = 1'b1;
      mem_rdata = shrd(mem_addr);
      if (mem_wmask != 4'h0) begin
        w = shrd(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_wmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        shmem[mem_addr] = w;
      end
      counting = 1'b0;
    end else begin
      left--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    responder();
  endtask

  task automatic clear_cpu();
    imem_addr = 0; imem_rmask = 0;
    dmem_addr = 0; dmem_rmask = 0; dmem_wmask = 0; dmem_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_cpu();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_resp(input bit is_d, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (is_d ? dmem_resp : imem_resp) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int n, i_seen, d_seen, kind;
    int seq [4];
    bit i_act, d_act;

    rst = 1'b1; mem_resp = 1'b0; mem_rdata = 0;
    clear_cpu();
    do_reset();

    // Reset state.
    @(negedge clk);
    check("reset mem_rmask", mem_rmask, 0);
    check("reset timeout_err", timeout_err, 0);

    // Single imem read, memory replies one cycle after the request appears.
    shmem[32'h6000_0000] = 32'h0000_0013;
    min_delay = 1; max_delay = 1;
    tick();
    imem_addr = 32'h6000_0000; imem_rmask = 4'hF;
    @(negedge clk);
    check("t1 mem_rmask cycle N", mem_rmask, 4'h0);
    tick();
    @(negedge clk);
    check("t1 mem_rmask cycle N+1", mem_rmask, 4'hF);
    check("t1 mem_addr", mem_addr, 32'h6000_0000);
    tick();
    @(negedge clk);
    check("t1 imem_resp", imem_resp, 1);
    check("t1 imem_rdata", imem_rdata, 32'h13);
    check("t1 dmem_resp", dmem_resp, 0);
    tick();
    imem_rmask = 0;

    // Single dmem partial write, then read it back.
    dmem_addr = 32'h6000_1000; dmem_wmask = 4'h3; dmem_wdata = 32'hDEAD_BEEF;
    tick();
    @(negedge clk);
    check("t2 mem_wmask", mem_wmask, 4'h3);
    check("t2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t2 mem_rmask", mem_rmask, 4'h0);
    tick();
    @(negedge clk);
    check("t2 dmem_resp", dmem_resp, 1);
    tick();
    dmem_wmask = 0; dmem_rmask = 4'hF;
    wait_resp(1'b1, 10, ok);
    check("t2 read resp seen", ok, 1);
    check("t2 read rdata", dmem_rdata, 32'h0000_BEEF);
    tick();
    clear_cpu();

    // Continuous contention after reset: D,I,D,I.
    do_reset();
    imem_addr = 32'h6000_0100; imem_rmask = 4'hF;
    dmem_addr = 32'h6000_0200; dmem_rmask = 4'hF;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (imem_resp) begin
        check("t3 I owner addr", mem_addr, 32'h6000_0100);
        seq[n] = 1; n++;
      end else if (dmem_resp) begin
        check("t3 D owner addr", mem_addr, 32'h6000_0200);
        seq[n] = 2; n++;
      end
      tick();
    end
    clear_cpu();
    check("t3 four grants", n, 4);
    if (n == 4) begin
      check("t3 grant0", seq[0], 2);
      check("t3 grant1", seq[1], 1);
      check("t3 grant2", seq[2], 2);
      check("t3 grant3", seq[3], 1);
    end

    // dmem_addr changes mid-transaction; the memory side holds 0x100.
    min_delay = 3; max_delay = 3;
    tick();
    dmem_addr = 32'h100; dmem_rmask = 4'hF;
    tick();
    dmem_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4 mem_addr held", mem_addr, 32'h100);
      if (k == 3) check("t4 dmem_resp", dmem_resp, 1);
      tick();
    end
    clear_cpu();

    // Memory never answers: watchdog fires after TO busy cycles.
    do_reset();
    auto_mem = 1'b0;
    imem_addr = 32'h6000_0040; imem_rmask = 4'hF;
    tick();
    for (int k = 1; k <= TO + 4; k++) begin
      @(negedge clk);
      check("t5 timeout_err", timeout_err, (k > TO) ? 1 : 0);
      tick();
    end
    do_reset();
    @(negedge clk);
    check("t5 err cleared", timeout_err, 0);
    check("t5 idle after rst", mem_rmask, 0);

    // Reset in the same cycle as mem_resp during an imem transaction.
    tick();
    imem_addr = 32'h6000_0080; imem_rmask = 4'hF;
    tick();
    rst = 1'b1; mem_resp = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    check("t6 imem_resp dropped", imem_resp, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6 mem_rmask cleared", mem_rmask, 0);
    tick();
    @(negedge clk);
    check("t6 regrant", mem_rmask, 4'hF);
    auto_mem = 1'b1;
    min_delay = 0; max_delay = 3;
    tick();
    wait_resp(1'b0, 10, ok);
    check("t6 resp after regrant", ok, 1);
    tick();
    clear_cpu();

    // Random traffic against the model.
    i_act = 0; d_act = 0;
    i_seen = i_resp_cnt; d_seen = d_resp_cnt;
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      if (i_resp_cnt != i_seen) begin
        i_seen = i_resp_cnt; i_act = 0; imem_rmask = 0;
      end
      if (d_resp_cnt != d_seen) begin
        d_seen = d_resp_cnt; d_act = 0; dmem_rmask = 0; dmem_wmask = 0;
      end
      if (!i_act && $urandom_range(0, 1) == 1) begin
        i_act = 1;
        imem_addr  = 32'h6000_0000 + 32'(4 * $urandom_range(0, 7));
        imem_rmask = 4'($urandom_range(1, 15));
      end else if (i_act && $urandom_range(0, 7) == 0) begin
        imem_addr = $urandom();
      end
      if (!d_act && $urandom_range(0, 1) == 1) begin
        d_act = 1;
        kind = $urandom_range(0, 7);
        dmem_addr  = 32'h6000_0000 + 32'(4 * $urandom_range(0, 7));
        dmem_wdata = $urandom();
        dmem_rmask = (kind <= 3 || kind == 7) ? 4'($urandom_range(1, 15)) : 4'h0;
        dmem_wmask = (kind >= 4) ? 4'($urandom_range(1, 15)) : 4'h0;
      end else if (d_act && $urandom_range(0, 7) == 0) begin
        dmem_addr = $urandom();
      end
    end
    rst = 1'b0;
    clear_cpu();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
